vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller. Generates hsync/vsync/video_on for any mode set by parameters.
- Adds programmable sync polarity, pixel replication (2^SCALE_SHIFT), pixel coordinates, line/frame strobes, and a sync-delay pipeline that aligns the timing outputs with SRAM read latency.
- Sits between the pixel clock domain and the frame-buffer SRAM read port.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- SCALE_SHIFT, 0, pixel replication factor log2 (0..3); each framebuffer pixel covers 2^S x 2^S screen pixels
- PIPE_LAT, 1, SRAM read latency in clocks (0..4); delay applied to timing outputs
- ADDR_W, 19, sram_addr width

Ports:
- clk_25mhz  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- en  in  1  advance enable; low freezes all state, including the pipeline
- hsync  out  1  horizontal sync, level per HSYNC_POL, delayed PIPE_LAT
- vsync  out  1  vertical sync, level per VSYNC_POL, delayed PIPE_LAT
- video_on  out  1  visible-area flag, delayed PIPE_LAT
- pix_x  out  12  visible column 0..H_ACTIVE-1, undelayed; 0 outside the visible area
- pix_y  out  12  visible row 0..V_ACTIVE-1, undelayed; 0 outside the visible area
- line_start  out  1  one-clock pulse on the first visible pixel of each visible line, undelayed
- frame_start  out  1  one-clock pulse on pixel (0,0), undelayed
- sram_addr  out  ADDR_W  framebuffer read address, undelayed
- irq_clr  in  1  clears vblank_irq (optional feature)
- vblank_irq  out  1  sticky vertical-blank flag (optional feature)

Behaviour:
- Reset: h and v FSMs in VISIBLE with counts 0. sram_addr=0 and line base=0. pix_x/pix_y=0. Pipeline filled with inactive values (video_on=0, syncs at inactive level). line_start and frame_start are 0 during reset. On the first enabled clock after reset, frame_start=1 and line_start=1.
- H FSM states (package state_t) are VISIBLE, FRONT_PORCH, SYNC_PULSE, BACK_PORCH. Each state's counter runs 0..LEN-1, then the FSM moves to the next state and the counter resets to 0.
- End of line is the last BACK_PORCH clock. The V FSM advances only on end of line, using the same state sequence with V_* lengths.
- Raw sync is asserted in SYNC_PULSE. Output = raw XNOR POL, so with POL=0 the output is low during the pulse.
- Addressing with S=SCALE_SHIFT and W=H_ACTIVE>>S:
  - sram_addr increments when both FSMs are VISIBLE and the low S bits of h_cnt are all 1. It therefore holds each address for 2^S clocks.
  - At the end of each visible line: if the low S bits of v_cnt are all 1, line_base += W; otherwise line_base is unchanged. In both cases sram_addr reloads to the new line_base.
  - Frame end (last BACK_PORCH clock of the last V BACK_PORCH line) sets line_base and sram_addr to 0.
  - Address arithmetic truncates to ADDR_W bits.
- Pipeline: hsync, vsync and video_on pass through a PIPE_LAT-deep shift register, so the data for sram_addr issued at cycle t meets video_on at cycle t+PIPE_LAT. With PIPE_LAT=0 the paths are combinational from state.
- en low: no counter, address or pipeline stage changes; strobes are 0.
- Reset asserted mid-frame: immediate return to the reset state; no partial pulses afterwards.

Optional Feature:
- Macro VGA_VBLANK_IRQ_EN.
- Defined: vblank_irq sets on the first clock where v_state leaves VISIBLE for FRONT_PORCH. It stays high until irq_clr is sampled high. If set and clear occur in the same cycle, set wins. Reset value is 0.
- Undefined: vblank_irq is tied 0 and irq_clr is ignored.

Decomposition:
- vga_pkg holds state_t and default timing constants (H_ACTIVE etc.) reused as parameter defaults.
- One sub-module, vga_delay_line: a parametrised-depth shift register with enable and reset value, used for the 3-bit sync/video bundle.

Test Plan:
- Default params, PIPE_LAT=0, S=0:
  - 800 clocks per line; hsync low for exactly clocks 656..751.
  - vsync low for lines 490..491.
  - sram_addr reaches 307199 at pixel (639,479), then returns to 0 at frame_start.
- S=1: each address is held 2 clocks, and each row of addresses is repeated for 2 lines. Line 2 starts at addr 320; last visible addr is 76799.
- PIPE_LAT=2: video_on rises exactly 2 clocks after frame_start, and hsync/vsync are likewise shifted by 2 clocks.
- HSYNC_POL=1 with small mode (H 8/2/2/2, V 4/1/1/1): hsync is high for 2 clocks per 14-clock line; the frame is 7 lines.
- en toggled 1 clock on, 1 off: period doubles, with no duplicated or skipped addresses. Reset at pixel (100,50): all outputs are back at reset values within the same cycle.
- VGA_VBLANK_IRQ_EN: vblank_irq rises at line 480, holds through irq_clr=0, and clears the clock after irq_clr=1. Set and clear in the same cycle leaves it at 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing generator.
// The per-state length and successor helpers are shared by the H and V state machines.
package vga_pkg;

  typedef enum logic [1:0] {
    VISIBLE     = 2'd0,
    FRONT_PORCH = 2'd1,
    SYNC_PULSE  = 2'd2,
    BACK_PORCH  = 2'd3
  } state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic state_t next_state(state_t s);
    state_t n;
    case (s)
      VISIBLE:     n = FRONT_PORCH;
      FRONT_PORCH: n = SYNC_PULSE;
      SYNC_PULSE:  n = BACK_PORCH;
      default:     n = VISIBLE;
    endcase
    return n;
  endfunction

  function automatic logic [11:0] seg_len(state_t s, int a, int f, int sy, int b);
    logic [11:0] len;
    case (s)
      VISIBLE:     len = 12'(a);
      FRONT_PORCH: len = 12'(f);
      SYNC_PULSE:  len = 12'(sy);
      default:     len = 12'(b);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a configurable reset pattern.
// DEPTH of 0 degenerates to a straight wire.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ rst ^ en_i;
      assign q_o = d_i;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        logic [WIDTH-1:0] stage_q;
        if (gi == 0) begin : g_first
          assign stage_d = d_i;
        end else begin : g_next
          assign stage_d = g_stage[gi-1].stage_q;
        end
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            stage_q <= RST_VAL;
          end else if (en_i) begin
            stage_q <= stage_d;
          end
        end
      end
      assign q_o = g_stage[DEPTH-1].stage_q;
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel replication and SRAM-latency-aligned syncs.
// Define VGA_VBLANK_IRQ_EN to build the sticky vertical-blank interrupt flag.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int SCALE_SHIFT = 0,
  parameter int PIPE_LAT    = 1,
  parameter int ADDR_W      = 19
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              en,
  input  logic              irq_clr,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [11:0]       pix_x,
  output logic [11:0]       pix_y,
  output logic              line_start,
  output logic              frame_start,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              vblank_irq
);

  localparam logic              HPOL       = (HSYNC_POL != 0);
  localparam logic              VPOL       = (VSYNC_POL != 0);
  localparam logic [11:0]       SCALE_MASK = 12'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  state_t            h_state_q, h_state_d, v_state_q, v_state_d;
  logic [11:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
  logic              h_last, v_last, end_of_line, end_of_frame, visible;
  logic [2:0]        tim_raw, tim_dly;

  assign h_last       = (h_cnt_q == seg_len(h_state_q, H_ACTIVE, H_FP, H_SYNC, H_BP) - 12'd1);
  assign v_last       = (v_cnt_q == seg_len(v_state_q, V_ACTIVE, V_FP, V_SYNC, V_BP) - 12'd1);
  assign end_of_line  = (h_state_q == BACK_PORCH) && h_last;
  assign end_of_frame = end_of_line && (v_state_q == BACK_PORCH) && v_last;
  assign visible      = (h_state_q == VISIBLE) && (v_state_q == VISIBLE);

  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    if (en) begin
      if (h_last) begin
        h_state_d = next_state(h_state_q);
        h_cnt_d   = '0;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
      if (end_of_line) begin
        if (v_last) begin
          v_state_d = next_state(v_state_q);
          v_cnt_d   = '0;
        end else begin
          v_cnt_d = v_cnt_q + 12'd1;
        end
      end
    end
  end

  // A framebuffer row is reused for 2^S lines; the base only steps on the last of them.
  always_comb begin
    base_d = base_q;
    addr_d = addr_q;
    if (en) begin
      if (end_of_frame) begin
        base_d = '0;
        addr_d = '0;
      end else if (end_of_line && (v_state_q == VISIBLE)) begin
        if ((v_cnt_q & SCALE_MASK) == SCALE_MASK) begin
          base_d = base_q + LINE_STEP;
        end
        addr_d = base_d;
      end else if (visible && ((h_cnt_q & SCALE_MASK) == SCALE_MASK)) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      h_state_q <= VISIBLE;
      v_state_q <= VISIBLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      addr_q    <= '0;
      base_q    <= '0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
    end
  end

  assign tim_raw = {~((h_state_q == SYNC_PULSE) ^ HPOL),
                    ~((v_state_q == SYNC_PULSE) ^ VPOL),
                    visible};

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_LAT),
    .RST_VAL({~HPOL, ~VPOL, 1'b0})
  ) u_dly (
    .clk (clk_25mhz),
    .rst (rst),
    .en_i(en),
    .d_i (tim_raw),
    .q_o (tim_dly)
  );

  assign hsync       = tim_dly[2];
  assign vsync       = tim_dly[1];
  assign video_on    = tim_dly[0];
  assign pix_x       = visible ? h_cnt_q : 12'd0;
  assign pix_y       = visible ? v_cnt_q : 12'd0;
  assign line_start  = en && !rst && visible && (h_cnt_q == 12'd0);
  assign frame_start = line_start && (v_cnt_q == 12'd0);
  assign sram_addr   = addr_q;

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q, irq_d;

  // Set takes priority so an edge landing with a clear is never lost.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) begin
      irq_d = 1'b0;
    end
    if (en && end_of_line && (v_state_q == VISIBLE) && v_last) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign vblank_irq = irq_q;
`else
  logic irq_clr_unused;
  assign irq_clr_unused = irq_clr;
  assign vblank_irq     = 1'b0;
`endif

endmodule
